// File: rtl/rptr_empty_pkg.sv
// rptr_empty_pkg: Gray/binary pointer helpers shared by both FIFO pointer blocks
package rptr_empty_pkg;
    typedef logic [1:0] quad_t;
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) b = b ^ (g >> i);
        return b;
    endfunction
endpackage

// File: rtl/rptr_empty_sync_w2r.sv
// rptr_empty_sync_w2r: multi-stage synchronizer carrying the write Gray pointer into the read clock
module rptr_empty_sync_w2r #(
    parameter int ASIZE       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_rclk,
    input  logic             i_rrst,
    input  logic [ASIZE-1:0] i_d,
    output logic [ASIZE-1:0] o_q
);
    logic [ASIZE-1:0] r_q [SYNC_STAGES];
    always_ff @(posedge i_rclk) begin
        if (i_rrst) begin
            r_q <= '{default: '0};
        end else begin
            r_q[0] <= i_d;
            for (int i = 1; i < SYNC_STAGES; i++) r_q[i] <= r_q[i-1];
        end
    end
    assign o_q = r_q[SYNC_STAGES-1];
endmodule

// File: rtl/rptr_empty.sv
// rptr_empty: read pointer, empty/almost-empty flags and occupancy for the async FIFO read domain
module rptr_empty
    import rptr_empty_pkg::*;
#(
    parameter int ASIZE       = 4,
    parameter int AE_THRESH   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_rclk,
    input  logic             i_rrst,
    input  logic             i_rinc,
    input  logic [ASIZE-1:0] i_wptr,
    output logic [ASIZE-1:0] o_raddr,
    output logic [ASIZE-1:0] o_rptr,
    output logic             o_rempty,
    output logic             o_raempty,
    output logic [ASIZE:0]   o_rlevel
);
    localparam int DEPTH = 1 << ASIZE;
    logic [ASIZE-1:0] w_rq_wptr, w_rq_wbin, w_rbnext, w_rgnext, w_diff, r_rbin, r_rptr;
    logic [ASIZE:0]   w_lvl_next, r_rlevel;
    logic             w_pop, w_dir_next, r_dir, r_rempty, r_raempty;
    quad_t            w_rq, w_wq;
    rptr_empty_sync_w2r #(.ASIZE(ASIZE), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .i_rclk (i_rclk),
        .i_rrst (i_rrst),
        .i_d    (i_wptr),
        .o_q    (w_rq_wptr)
    );
    always_comb begin
        w_rq_wbin  = ASIZE'(gray2bin(32'(w_rq_wptr)));
        w_pop      = i_rinc & ~r_rempty;
        w_rbnext   = r_rbin + {{(ASIZE-1){1'b0}}, w_pop};
        w_rgnext   = ASIZE'(bin2gray(32'(w_rbnext)));
        w_rq       = w_rbnext[ASIZE-1:ASIZE-2];
        w_wq       = w_rq_wbin[ASIZE-1:ASIZE-2];
        w_dir_next = (w_wq == w_rq - 2'd1) ? 1'b1 : (w_wq == w_rq + 2'd1) ? 1'b0 : r_dir;
        w_diff     = w_rq_wbin - w_rbnext;
        w_lvl_next = (w_diff == '0 && r_dir) ? (ASIZE+1)'(DEPTH) : {1'b0, w_diff};
    end
    always_ff @(posedge i_rclk) begin
        if (i_rrst) begin
            r_rbin    <= '0;
            r_rptr    <= '0;
            r_dir     <= 1'b0;
            r_rempty  <= 1'b1;
            r_raempty <= 1'b1;
            r_rlevel  <= '0;
        end else begin
            r_rbin    <= w_rbnext;
            r_rptr    <= w_rgnext;
            r_dir     <= w_dir_next;
            r_rempty  <= (w_diff == '0) && !r_dir;
            r_raempty <= w_lvl_next <= (ASIZE+1)'(AE_THRESH);
            r_rlevel  <= w_lvl_next;
        end
    end
    assign o_raddr   = r_rbin;
    assign o_rptr    = r_rptr;
    assign o_rempty  = r_rempty;
    assign o_raempty = r_raempty;
    assign o_rlevel  = r_rlevel;
endmodule

// File: tb/tb_rptr_empty.sv
// tb_rptr_empty: directed stimulus with queued expectations checked by a negedge monitor
module tb_rptr_empty;
    logic       clk = 1'b0;
    logic       i_rrst = 1'b1, i_rinc = 1'b0;
    logic [3:0] i_wptr = '0;
    logic [3:0] o_raddr, o_rptr;
    logic       o_rempty, o_raempty;
    logic [4:0] o_rlevel;
    typedef struct {
        string       name;
        logic [14:0] v;
    } exp_t;
    exp_t q[$];
    int   total = 0, passed = 0;
    rptr_empty #(.ASIZE(4), .AE_THRESH(1), .SYNC_STAGES(2)) dut (
        .i_rclk    (clk),
        .i_rrst    (i_rrst),
        .i_rinc    (i_rinc),
        .i_wptr    (i_wptr),
        .o_raddr   (o_raddr),
        .o_rptr    (o_rptr),
        .o_rempty  (o_rempty),
        .o_raempty (o_raempty),
        .o_rlevel  (o_rlevel)
    );
    always #5 clk = ~clk;
    function automatic logic [3:0] g(input int b);
        logic [3:0] x;
        x = 4'(b);
        return x ^ (x >> 1);
    endfunction
    task automatic push(input string n, input int addr, input bit e, input bit ae, input int lvl);
        exp_t x;
        x.name = n;
        x.v    = {4'(addr), g(addr), e, ae, 5'(lvl)};
        q.push_back(x);
    endtask
    task automatic cyc(input bit rst, input bit rinc, input int wb);
        i_rrst = rst;
        i_rinc = rinc;
        i_wptr = g(wb);
        @(posedge clk);
        #1;
    endtask
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            total++;
            if ({o_raddr, o_rptr, o_rempty, o_raempty, o_rlevel} === e.v) passed++;
            else $display("FAIL %s: got raddr=%0d rptr=%b rempty=%b raempty=%b rlevel=%0d, want raddr=%0d rptr=%b rempty=%b raempty=%b rlevel=%0d",
                          e.name, o_raddr, o_rptr, o_rempty, o_raempty, o_rlevel,
                          e.v[14:11], e.v[10:7], e.v[6], e.v[5], e.v[4:0]);
        end
    end
    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal;
    end
    initial begin
        int addr, lvl;
        repeat (3) begin
            cyc(1, 0, 0);
            push("reset", 0, 1, 1, 0);
        end
        cyc(0, 1, 0);
        push("rinc_when_empty", 0, 1, 1, 0);
        for (int e = 1; e <= 3; e++) begin
            cyc(0, 0, 1);
            push("write1_latency", 0, e < 3, 1, e == 3 ? 1 : 0);
        end
        cyc(0, 1, 1);
        push("pop_last", 1, 1, 1, 0);
        cyc(0, 1, 1);
        push("pop_while_empty", 1, 1, 1, 0);
        cyc(1, 0, 0);
        push("reset_before_fill", 0, 1, 1, 0);
        for (int j = 1; j <= 18; j++) begin
            cyc(0, 0, j <= 16 ? j % 16 : 0);
            lvl = (j <= 2) ? 0 : j - 2;
            push("fill_to_full", 0, lvl == 0, lvl <= 1, lvl);
        end
        for (int n = 1; n <= 16; n++) begin
            cyc(0, 1, 0);
            push("drain_from_full", n, n == 16, 16 - n <= 1, 16 - n);
        end
        cyc(0, 1, 0);
        push("drain_extra_rinc", 0, 1, 1, 0);
        for (int e = 1; e <= 9; e++) begin
            cyc(0, 1, 5);
            addr = (e < 3) ? 0 : ((e - 3 > 5) ? 5 : e - 3);
            lvl  = (e < 3) ? 0 : 5 - addr;
            push("almost_empty_run", addr, lvl == 0, lvl <= 1, lvl);
        end
        for (int e = 1; e <= 3; e++) begin
            cyc(0, 0, 14);
            push("level9", 5, e < 3, e < 3, e == 3 ? 9 : 0);
        end
        cyc(1, 1, 0);
        push("mid_stream_reset", 0, 1, 1, 0);
        for (int e = 1; e <= 3; e++) begin
            cyc(0, 0, 2);
            push("resume_after_reset", 0, e < 3, e < 3, e == 3 ? 2 : 0);
        end
        cyc(0, 1, 2);
        push("resume_pop", 1, 0, 1, 1);
        for (int c = 1; c <= 20; c++) begin
            cyc(0, 1, 2 + c);
            addr = (c <= 3) ? 2 : c - 1;
            lvl  = (c <= 2) ? 0 : 1;
            push("concurrent_stream", addr, lvl == 0, 1, lvl);
        end
        cyc(0, 1, 22);
        push("stream_tail", 20, 0, 1, 1);
        cyc(0, 1, 22);
        push("stream_tail", 21, 0, 1, 1);
        cyc(0, 1, 22);
        push("stream_empty", 22, 1, 1, 0);
        cyc(0, 1, 22);
        push("stream_idle_rinc", 22, 1, 1, 0);
        @(negedge clk);
        #1;
        if (passed != total) $display("FAIL %0d checks failed", total - passed);
        if (total < 12) $display("FAIL too few checks: %0d", total);
        if (q.size() != 0) $display("FAIL %0d expectations unchecked", q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
